// File: rtl/reg_dump_reader_if.sv
// Stream bundle carrying dumped register beats toward the debug path.
// master drives beats, slave returns out_ready.
interface reg_dump_reader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_last;
   logic              out_sum;

   modport master (
      output out_valid, out_data, out_addr, out_last, out_sum,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_data, out_addr, out_last, out_sum,
      output out_ready
   );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks a register range through a spare read port and streams each value out.
// Optional trailing XOR checksum beat when DUMP_CHECKSUM_EN is defined.
module reg_dump_reader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic              abort,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              busy,
   output logic              done,
   reg_dump_reader_if.master dump
);

   typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [ADDR_W-1:0] stop_q, stop_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              done_q, done_d;
   logic              accept;
`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;
   logic              sum_q, sum_d;
`endif

   assign accept = valid_q & dump.out_ready;

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      stop_d  = stop_q;
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      done_d  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_d  = csum_q;
      sum_d   = sum_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               cur_d   = start_addr;
               stop_d  = end_addr;
               state_d = READ;
`ifdef DUMP_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         READ: begin
            data_d  = rf_data;
            addr_d  = cur_q;
            valid_d = 1'b1;
            state_d = SEND;
`ifdef DUMP_CHECKSUM_EN
            last_d  = 1'b0;
            sum_d   = 1'b0;
`else
            last_d  = (cur_q == stop_q);
`endif
         end
         SEND: begin
            if (accept) begin
`ifdef DUMP_CHECKSUM_EN
               if (sum_q) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else if (cur_q == stop_q) begin
                  // checksum beat follows the last register beat back-to-back
                  csum_d = csum_q ^ data_q;
                  data_d = csum_q ^ data_q;
                  addr_d = '0;
                  last_d = 1'b1;
                  sum_d  = 1'b1;
               end else begin
                  csum_d  = csum_q ^ data_q;
                  cur_d   = cur_q + 1'b1;
                  valid_d = 1'b0;
                  state_d = READ;
               end
`else
               if (last_q) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  cur_d   = cur_q + 1'b1;
                  valid_d = 1'b0;
                  state_d = READ;
               end
`endif
            end
         end
         DONE: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // abort beats any same-cycle acceptance
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         valid_d = 1'b0;
         done_d  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum_d  = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cur_q   <= '0;
         stop_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum_q  <= '0;
         sum_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         stop_q  <= stop_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
`ifdef DUMP_CHECKSUM_EN
         csum_q  <= csum_d;
         sum_q   <= sum_d;
`endif
      end
   end

   assign rf_addr        = cur_q;
   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign dump.out_valid = valid_q;
   assign dump.out_data  = data_q;
   assign dump.out_addr  = addr_q;
   assign dump.out_last  = last_q;
`ifdef DUMP_CHECKSUM_EN
   assign dump.out_sum   = sum_q;
`else
   assign dump.out_sum   = 1'b0;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: vector table, random dumps vs. a queue model,
// and hand-written stall / abort / reset sequences.
module tb_reg_dump_reader;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      logic        l;
      logic        s;
   } beat_t;

   typedef struct {
      logic [4:0] s;
      logic [4:0] e;
      int         pct;
      int         n;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  start_addr;
   logic [4:0]  end_addr;
   logic        abort;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        busy;
   logic        done;
   logic [31:0] rf [32];

   int checks = 0;
   int errors = 0;

   reg_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) s_if ();

   reg_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .end_addr   (end_addr),
      .abort      (abort),
      .rf_addr    (rf_addr),
      .rf_data    (rf_data),
      .busy       (busy),
      .done       (done),
      .dump       (s_if)
   );

   always #5 clk = ~clk;

   assign rf_data = rf[rf_addr];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_dump(input logic [4:0] s, input logic [4:0] e,
                           input int pct, input int exp_n);
      beat_t       q[$];
      logic [4:0]  diff;
      logic [4:0]  a;
      logic [31:0] x;
      int          n;
      int          idx;
      int          t;
      logic        pend;
      x    = '0;
      diff = e - s;
      n    = int'(diff) + 1;
      if (exp_n > 0) chk("beat_count", n, exp_n);
      for (int i = 0; i < n; i++) begin
         a = s + 5'(i);
`ifdef DUMP_CHECKSUM_EN
         q.push_back('{a, rf[a], 1'b0, 1'b0});
`else
         q.push_back('{a, rf[a], (i == n - 1), 1'b0});
`endif
         x = x ^ rf[a];
      end
`ifdef DUMP_CHECKSUM_EN
      q.push_back('{5'd0, x, 1'b1, 1'b1});
`endif
      start      = 1'b1;
      start_addr = s;
      end_addr   = e;
      cyc();
      start = 1'b0;
      chk1("lat1_valid", s_if.out_valid, 1'b0);
      chk1("lat1_busy", busy, 1'b1);
      cyc();
      chk1("lat2_valid", s_if.out_valid, 1'b1);
      idx  = 0;
      t    = 0;
      pend = 1'b0;
      while (idx < q.size() && t < 4000) begin
         if (pend) chk1("valid_hold", s_if.out_valid, 1'b1);
         s_if.out_ready = ($urandom_range(99) < pct);
         if (s_if.out_valid && s_if.out_ready) begin
            chk("beat_addr", 32'(s_if.out_addr), 32'(q[idx].a));
            chk("beat_data", s_if.out_data, q[idx].d);
            chk1("beat_last", s_if.out_last, q[idx].l);
            chk1("beat_sum", s_if.out_sum, q[idx].s);
            idx++;
            pend = 1'b0;
         end else begin
            pend = s_if.out_valid;
         end
         cyc();
         t++;
      end
      s_if.out_ready = 1'b0;
      if (idx < q.size()) begin
         checks++;
         errors++;
         $display("FAIL dump_timeout: got %0d beats expected %0d",
                  idx, q.size());
      end else begin
         chk1("done_pulse", done, 1'b1);
         chk1("done_valid", s_if.out_valid, 1'b0);
         cyc();
         chk1("done_clear", done, 1'b0);
         chk1("idle_busy", busy, 1'b0);
      end
   endtask

   initial begin
      vec_t        vecs[8];
      logic [31:0] old7;
      rst            = 1'b0;
      start          = 1'b0;
      start_addr     = '0;
      end_addr       = '0;
      abort          = 1'b0;
      s_if.out_ready = 1'b0;
      rf[0] = '0;
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      rf[5] = 32'hDEADBEEF;
      rf[6] = 32'h12345678;
      rf[1] = 32'h0F0F0F0F;
      rf[2] = 32'hFF00FF00;

      vecs[0] = '{5'd5,  5'd6,  100, 2};
      vecs[1] = '{5'd30, 5'd1,  100, 4};
      vecs[2] = '{5'd0,  5'd31, 100, 32};
      vecs[3] = '{5'd9,  5'd9,  100, 1};
      vecs[4] = '{5'd31, 5'd0,  50,  2};
      vecs[5] = '{5'd1,  5'd2,  100, 2};
      vecs[6] = '{5'd20, 5'd3,  60,  16};
      vecs[7] = '{5'd12, 5'd12, 30,  1};

      @(negedge clk);
      cyc();
      cyc();
      chk1("rst_valid", s_if.out_valid, 1'b0);
      chk("rst_data", s_if.out_data, 32'd0);
      chk("rst_addr", 32'(s_if.out_addr), 32'd0);
      chk1("rst_last", s_if.out_last, 1'b0);
      chk1("rst_sum", s_if.out_sum, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk("rst_rf_addr", 32'(rf_addr), 32'd0);
      rst = 1'b1;
      cyc();

      foreach (vecs[i]) run_dump(vecs[i].s, vecs[i].e, vecs[i].pct, vecs[i].n);

      // stall on x7 while x7 is rewritten underneath the held beat
      rf[7]      = 32'h11112222;
      old7       = rf[7];
      start      = 1'b1;
      start_addr = 5'd7;
      end_addr   = 5'd7;
      cyc();
      start = 1'b0;
      cyc();
      for (int k = 0; k < 5; k++) begin
         chk1("stall_valid", s_if.out_valid, 1'b1);
         chk("stall_data", s_if.out_data, old7);
         if (k == 0) rf[7] = 32'hAAAA0000;
         cyc();
      end
      s_if.out_ready = 1'b1;
      chk("stall_accept", s_if.out_data, old7);
      cyc();
`ifdef DUMP_CHECKSUM_EN
      chk1("stall_sum", s_if.out_sum, 1'b1);
      chk("stall_csum", s_if.out_data, old7);
      cyc();
`endif
      s_if.out_ready = 1'b0;
      chk1("stall_done", done, 1'b1);
      cyc();

      // abort during SEND of beat 1 of 0..31, stray start mid-dump
      start      = 1'b1;
      start_addr = 5'd0;
      end_addr   = 5'd31;
      cyc();
      start = 1'b0;
      cyc();
      s_if.out_ready = 1'b1;
      start          = 1'b1;
      start_addr     = 5'd9;
      end_addr       = 5'd9;
      chk("abort_b0_addr", 32'(s_if.out_addr), 32'd0);
      cyc();
      start          = 1'b0;
      s_if.out_ready = 1'b0;
      cyc();
      chk1("abort_b1_valid", s_if.out_valid, 1'b1);
      chk("abort_b1_addr", 32'(s_if.out_addr), 32'd1);
      abort          = 1'b1;
      s_if.out_ready = 1'b1;
      cyc();
      abort          = 1'b0;
      s_if.out_ready = 1'b0;
      chk1("abort_valid", s_if.out_valid, 1'b0);
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_done", done, 1'b0);
      cyc();
      chk1("abort_done2", done, 1'b0);
      chk1("abort_idle", busy, 1'b0);

      // reset in the middle of a dump
      start      = 1'b1;
      start_addr = 5'd0;
      end_addr   = 5'd31;
      cyc();
      start          = 1'b0;
      s_if.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) cyc();
      s_if.out_ready = 1'b0;
      rst = 1'b0;
      cyc();
      cyc();
      chk1("mrst_valid", s_if.out_valid, 1'b0);
      chk("mrst_data", s_if.out_data, 32'd0);
      chk("mrst_addr", 32'(s_if.out_addr), 32'd0);
      chk1("mrst_last", s_if.out_last, 1'b0);
      chk1("mrst_busy", busy, 1'b0);
      chk1("mrst_done", done, 1'b0);
      chk("mrst_rf_addr", 32'(rf_addr), 32'd0);
      rst = 1'b1;
      cyc();
      chk1("mrst_done2", done, 1'b0);
      run_dump(5'd3, 5'd4, 100, 2);

      for (int r = 0; r < 20; r++) begin
         for (int i = 1; i < 32; i++) rf[i] = $urandom;
         run_dump(5'($urandom_range(31)), 5'($urandom_range(31)),
                  int'($urandom_range(100, 30)), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
